// File: rtl/nn_sample_sequencer.sv
// Training-sample sequencer feeding the back-propagation network.
// Presents stored samples for a fixed hold window and tallies per-epoch mismatches.
module nn_sample_sequencer #(
    parameter int DEPTH       = 8,
    parameter int ADDR_W      = 3,
    parameter int HOLD_CYCLES = 24,
    parameter int EPOCH_W     = 8,
    parameter int ERR_W       = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [7:0]         wr_x0,
    input  logic [7:0]         wr_x1,
    input  logic [7:0]         wr_x2,
    input  logic [7:0]         wr_x3,
    input  logic               wr_d0,
    input  logic               wr_d1,
    input  logic [ADDR_W:0]    num_samples,
    input  logic [EPOCH_W-1:0] num_epochs,
    input  logic               start,
    input  logic               y0,
    input  logic               y1,
    output logic [8:0]         x0,
    output logic [8:0]         x1,
    output logic [8:0]         x2,
    output logic [8:0]         x3,
    output logic [8:0]         desired_y0,
    output logic [8:0]         desired_y1,
    output logic               sample_valid,
    output logic [ADDR_W-1:0]  sample_idx,
    output logic [EPOCH_W-1:0] epoch_cnt,
    output logic [ERR_W-1:0]   err_cnt,
    output logic               busy,
    output logic               done
);

    localparam int HC_W = $clog2(HOLD_CYCLES);
    localparam logic [HC_W-1:0]   HC_LAST = HC_W'(HOLD_CYCLES - 1);
    localparam logic [ADDR_W:0]   DEPTH_N = (ADDR_W + 1)'(DEPTH);
    localparam logic [ERR_W-1:0]  ERR_MAX = '1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [7:0] tx0 [DEPTH];
    logic [7:0] tx1 [DEPTH];
    logic [7:0] tx2 [DEPTH];
    logic [7:0] tx3 [DEPTH];
    logic       td0 [DEPTH];
    logic       td1 [DEPTH];

    logic [1:0]         state;
    logic [HC_W-1:0]    hold_cnt;
    logic [ADDR_W:0]    n_lat;
    logic [EPOCH_W-1:0] ep_lat;
    logic [ERR_W-1:0]   err_acc;

    logic [ADDR_W:0]    ns_clamp;
    logic               cfg_zero;
    logic               hold_end;
    logic               last_sample;
    logic               last_epoch;
    logic               mismatch;
    logic [ERR_W:0]     err_sum;
    logic [ERR_W-1:0]   err_next;
    logic               load;
    logic [ADDR_W-1:0]  load_idx;

    // Run-control decode: clamping, window end, mismatch and next-slot selection
    always_comb begin
        ns_clamp    = (num_samples > DEPTH_N) ? DEPTH_N : num_samples;
        cfg_zero    = (ns_clamp == '0) || (num_epochs == '0);
        hold_end    = (hold_cnt == HC_LAST);
        last_sample = ({1'b0, sample_idx} == (n_lat - (ADDR_W + 1)'(1)));
        last_epoch  = (epoch_cnt == (ep_lat - EPOCH_W'(1)));
        mismatch    = (y0 != desired_y0[0]) || (y1 != desired_y1[0]);
        err_sum     = {1'b0, err_acc} + (ERR_W + 1)'(mismatch);
        err_next    = err_sum[ERR_W] ? ERR_MAX : err_sum[ERR_W-1:0];
        load        = 1'b0;
        load_idx    = '0;
        if (state == IDLE) begin
            load = start && !cfg_zero;
        end else if (state == HOLD) begin
            load = hold_end && !(last_sample && last_epoch);
            if (!last_sample) begin
                load_idx = sample_idx + ADDR_W'(1);
            end
        end
    end

    // Sample table writes; writes are dropped while a run is active
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                tx0[i] <= '0;
                tx1[i] <= '0;
                tx2[i] <= '0;
                tx3[i] <= '0;
                td0[i] <= 1'b0;
                td1[i] <= 1'b0;
            end
        end else if (wr_en && !busy && ({1'b0, wr_addr} < DEPTH_N)) begin
            tx0[wr_addr] <= wr_x0;
            tx1[wr_addr] <= wr_x1;
            tx2[wr_addr] <= wr_x2;
            tx3[wr_addr] <= wr_x3;
            td0[wr_addr] <= wr_d0;
            td1[wr_addr] <= wr_d1;
        end
    end

    // Presented sample registers; they keep the last sample after a run
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            x0           <= '0;
            x1           <= '0;
            x2           <= '0;
            x3           <= '0;
            desired_y0   <= '0;
            desired_y1   <= '0;
            sample_idx   <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= load;
            if (load) begin
                x0         <= {1'b0, tx0[load_idx]};
                x1         <= {1'b0, tx1[load_idx]};
                x2         <= {1'b0, tx2[load_idx]};
                x3         <= {1'b0, tx3[load_idx]};
                desired_y0 <= {8'b0, td0[load_idx]};
                desired_y1 <= {8'b0, td1[load_idx]};
                sample_idx <= load_idx;
            end
        end
    end

    // Run FSM: hold timing, epoch counting and error accumulation
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            n_lat     <= '0;
            ep_lat    <= '0;
            err_acc   <= '0;
            err_cnt   <= '0;
            epoch_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        n_lat  <= ns_clamp;
                        ep_lat <= num_epochs;
                        if (cfg_zero) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= HOLD;
                            busy      <= 1'b1;
                            hold_cnt  <= '0;
                            epoch_cnt <= '0;
                            err_acc   <= '0;
                        end
                    end
                end
                HOLD: begin
                    hold_cnt <= hold_cnt + HC_W'(1);
                    if (hold_end) begin
                        hold_cnt <= '0;
                        if (!last_sample) begin
                            err_acc <= err_next;
                        end else begin
                            err_cnt   <= err_next;
                            err_acc   <= '0;
                            epoch_cnt <= epoch_cnt + EPOCH_W'(1);
                            if (last_epoch) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nn_sample_sequencer.sv
// Directed bench for nn_sample_sequencer.
// Sample table records drive both the writes and the expected presented values.
module tb_nn_sample_sequencer;

    logic       CLK;
    logic       RST;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_x0, wr_x1, wr_x2, wr_x3;
    logic       wr_d0, wr_d1;
    logic [3:0] num_samples;
    logic [7:0] num_epochs;
    logic       start;
    logic       y0, y1;
    logic [8:0] x0, x1, x2, x3;
    logic [8:0] desired_y0, desired_y1;
    logic       sample_valid;
    logic [2:0] sample_idx;
    logic [7:0] epoch_cnt;
    logic [15:0] err_cnt;
    logic       busy;
    logic       done;

    nn_sample_sequencer dut (
        .CLK(CLK),
        .RST(RST),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_x0(wr_x0),
        .wr_x1(wr_x1),
        .wr_x2(wr_x2),
        .wr_x3(wr_x3),
        .wr_d0(wr_d0),
        .wr_d1(wr_d1),
        .num_samples(num_samples),
        .num_epochs(num_epochs),
        .start(start),
        .y0(y0),
        .y1(y1),
        .x0(x0),
        .x1(x1),
        .x2(x2),
        .x3(x3),
        .desired_y0(desired_y0),
        .desired_y1(desired_y1),
        .sample_valid(sample_valid),
        .sample_idx(sample_idx),
        .epoch_cnt(epoch_cnt),
        .err_cnt(err_cnt),
        .busy(busy),
        .done(done)
    );

    typedef struct {
        logic [7:0] x0;
        logic [7:0] x1;
        logic [7:0] x2;
        logic [7:0] x3;
        logic       d0;
        logic       d1;
    } vec_t;

    vec_t vec [8];
    vec_t cur [8];
    int checks;
    int failures;
    int last_x0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic load_table();
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            wr_addr = 3'(i);
            wr_x0   = vec[i].x0;
            wr_x1   = vec[i].x1;
            wr_x2   = vec[i].x2;
            wr_x3   = vec[i].x3;
            wr_d0   = vec[i].d0;
            wr_d1   = vec[i].d1;
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic run(input int n_req, input int e_req, input int mode,
                       input bit disturb, input int exp_ep,
                       input int exp_err, input int exp_busy);
        int n_eff;
        int pulses;
        int busy_cyc;
        int k;
        int done_it;
        n_eff = (n_req > 8) ? 8 : n_req;
        num_samples = 4'(n_req);
        num_epochs  = 8'(e_req);
        start = 1'b1;
        tick();
        start = 1'b0;
        pulses = 0;
        busy_cyc = 0;
        k = 0;
        done_it = -1;
        for (int it = 0; it < exp_busy + 30 && done_it < 0; it++) begin
            if (busy) busy_cyc++;
            if (sample_valid) begin
                k = pulses % n_eff;
                pulses++;
                chk("sample_idx", sample_idx, k);
                chk("x0", x0, cur[k].x0);
                chk("x1", x1, cur[k].x1);
                chk("x2", x2, cur[k].x2);
                chk("x3", x3, cur[k].x3);
                chk("desired_y0", desired_y0, cur[k].d0);
                chk("desired_y1", desired_y1, cur[k].d1);
                if (k == 0 && pulses > 1) begin
                    chk("epoch_cnt_wrap", epoch_cnt, (pulses - 1) / n_eff);
                    chk("err_cnt_epoch", err_cnt, exp_err);
                end
                last_x0 = cur[k].x0;
            end
            if (done) done_it = it;
            y0 = (mode != 0) ? 1'b0 : cur[k].d0;
            y1 = (mode != 0) ? 1'b1 : cur[k].d1;
            if (disturb && it == 30) begin
                start       = 1'b1;
                num_samples = 4'd1;
                num_epochs  = 8'd9;
                wr_en       = 1'b1;
                wr_addr     = 3'd2;
                wr_x0       = 8'd7;
            end
            if (disturb && it == 31) begin
                start = 1'b0;
                wr_en = 1'b0;
            end
            if (done_it < 0) tick();
        end
        chk("done_cycle", done_it, exp_busy);
        chk("busy_cycles", busy_cyc, exp_busy);
        chk("valid_pulses", pulses, n_eff * e_req);
        chk("epoch_cnt_end", epoch_cnt, exp_ep);
        chk("err_cnt_end", err_cnt, exp_err);
        chk("x0_retained", x0, last_x0);
        chk("busy_at_done", busy, 0);
        if (done_it >= 0) begin
            tick();
            chk("done_width", done, 0);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        last_x0 = 0;
        vec[0] = '{8'd159, 8'd205, 8'd81, 8'd76, 1'b0, 1'b1};
        vec[1] = '{8'd168, 8'd218, 8'd37, 8'd36, 1'b0, 1'b1};
        vec[2] = '{8'd111, 8'd216, 8'd3, 8'd89, 1'b0, 1'b1};
        vec[3] = '{8'd238, 8'd216, 8'd9, 8'd8, 1'b0, 1'b1};
        vec[4] = '{8'd78, 8'd101, 8'd214, 8'd226, 1'b0, 1'b0};
        for (int i = 5; i < 8; i++) vec[i] = '{8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0};
        cur = vec;
        RST = 1'b1;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_x0 = '0;
        wr_x1 = '0;
        wr_x2 = '0;
        wr_x3 = '0;
        wr_d0 = 1'b0;
        wr_d1 = 1'b0;
        num_samples = '0;
        num_epochs = '0;
        start = 1'b0;
        y0 = 1'b0;
        y1 = 1'b0;
        tick();
        tick();
        chk("rst_x0", x0, 0);
        chk("rst_dy1", desired_y1, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_epoch", epoch_cnt, 0);
        chk("rst_err", err_cnt, 0);
        RST = 1'b0;
        tick();

        run(0, 1, 0, 1'b0, 0, 0, 0);
        run(5, 0, 0, 1'b0, 0, 0, 0);

        load_table();
        run(5, 1, 0, 1'b0, 1, 0, 120);
        run(5, 3, 1, 1'b0, 3, 1, 360);
        run(0, 2, 0, 1'b0, 3, 1, 0);
        run(5, 1, 0, 1'b1, 1, 0, 120);
        run(5, 1, 0, 1'b0, 1, 0, 120);
        run(15, 1, 0, 1'b0, 1, 0, 192);

        num_samples = 4'd5;
        num_epochs = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (50) tick();
        RST = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_x0", x0, 0);
        chk("midrst_dy1", desired_y1, 0);
        chk("midrst_idx", sample_idx, 0);
        chk("midrst_epoch", epoch_cnt, 0);
        tick();
        chk("midrst_done", done, 0);
        RST = 1'b0;
        last_x0 = 0;
        tick();
        for (int i = 0; i < 8; i++) cur[i] = '{8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0};
        run(5, 1, 0, 1'b0, 1, 0, 120);
        cur = vec;
        load_table();
        run(5, 1, 1, 1'b0, 1, 1, 120);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
